// File: rtl/cfu_cram_pkg.sv
// Shared opcodes, status layout and FSM encoding for the CRAM CFU dispatcher.
// Also provides a clog2 helper that never returns less than 1.
package cfu_cram_pkg;

  localparam logic [2:0] F3_SOFT_RST = 3'd0;
  localparam logic [2:0] F3_READBACK = 3'd6;
  localparam logic [2:0] F3_EXEC     = 3'd7;

  localparam logic [6:0] F7_SOFT_RST    = 7'd1;
  localparam logic [6:0] F7_RB_CONFIG   = 7'd0;
  localparam logic [6:0] F7_RB_READ     = 7'd1;
  localparam logic [6:0] F7_RB_HI       = 7'd2;
  localparam logic [6:0] F7_EX_START    = 7'd0;
  localparam logic [6:0] F7_EX_STATUS   = 7'd1;
  localparam logic [6:0] F7_EX_RF_WRITE = 7'd2;

  localparam int STAT_BUSY = 0;
  localparam int STAT_DONE = 1;
  localparam int STAT_WRAP = 2;

  localparam logic [31:0] RSP_UNSUPPORTED = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RD_WAIT = 2'd1,
    ST_RSP     = 2'd2
  } state_t;

  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cram_rd_ptr.sv
// Readback pointer: walks count words from start in one bank, then moves
// to the next bank; a sticky wrap flag marks the return to bank 0.
module cram_rd_ptr
  import cfu_cram_pkg::*;
#(
  parameter int NUM_CRAM = 4,
  parameter int AWIDTH   = 9,
  parameter int BANK_W   = 2
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              i_load,
  input  logic [AWIDTH-1:0] i_start,
  input  logic [31:0]       i_count,
  input  logic              i_clear,
  input  logic              i_advance,
  output logic [AWIDTH-1:0] o_addr,
  output logic [BANK_W-1:0] o_bank,
  output logic              o_wrap
);

  localparam logic [BANK_W-1:0] LAST_BANK = BANK_W'(NUM_CRAM - 1);

  logic [AWIDTH-1:0] r_start;
  logic [AWIDTH-1:0] r_addr;
  logic [31:0]       r_last;
  logic [31:0]       r_elem;
  logic [BANK_W-1:0] r_bank;
  logic              r_wrap;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_start <= '0;
      r_addr  <= '0;
      r_last  <= '0;
      r_elem  <= '0;
      r_bank  <= '0;
      r_wrap  <= 1'b0;
    end else if (i_load) begin
      r_start <= i_start;
      // r_last holds count-1; a zero count behaves as a single word
      r_last  <= (i_count == 32'd0) ? 32'd0 : i_count - 32'd1;
      r_addr  <= i_start;
      r_elem  <= '0;
      r_bank  <= '0;
      r_wrap  <= 1'b0;
    end else if (i_clear) begin
      r_addr  <= r_start;
      r_elem  <= '0;
      r_bank  <= '0;
      r_wrap  <= 1'b0;
    end else if (i_advance) begin
      if (r_elem == r_last) begin
        r_elem <= '0;
        r_addr <= r_start;
        if (r_bank == LAST_BANK) begin
          r_bank <= '0;
          r_wrap <= 1'b1;
        end else begin
          r_bank <= r_bank + 1'b1;
        end
      end else begin
        r_elem <= r_elem + 32'd1;
        r_addr <= r_addr + 1'b1;
      end
    end
  end

  assign o_addr = r_addr;
  assign o_bank = r_bank;
  assign o_wrap = r_wrap;

endmodule

// File: rtl/cfu_cram_dispatch.sv
// CFU command front-end for a multi-bank compute-RAM array: decodes
// readback, exec-control and register-file commands with rsp back-pressure.
module cfu_cram_dispatch
  import cfu_cram_pkg::*;
#(
  parameter int NUM_CRAM    = 4,
  parameter int CRAM_AWIDTH = 9,
  parameter int CRAM_DWIDTH = 40,
  parameter int RD_LAT      = 2,
  parameter int RF_AWIDTH   = 2,
  parameter int RF_DWIDTH   = 16
) (
  input  logic                            clk,
  input  logic                            resetn,
  input  logic                            cmd_valid,
  output logic                            cmd_ready,
  input  logic [9:0]                      cmd_payload_function_id,
  input  logic [31:0]                     cmd_payload_inputs_0,
  input  logic [31:0]                     cmd_payload_inputs_1,
  output logic                            rsp_valid,
  input  logic                            rsp_ready,
  output logic [31:0]                     rsp_payload_outputs_0,
  output logic [CRAM_AWIDTH-1:0]          cram_rd_addr,
  input  logic [NUM_CRAM*CRAM_DWIDTH-1:0] cram_rd_data,
  output logic                            exec_start,
  input  logic                            exec_done,
  output logic                            rf_wren,
  output logic [RF_AWIDTH-1:0]            rf_addr,
  output logic [RF_DWIDTH-1:0]            rf_data,
  output logic                            busy
);

  localparam int BANK_W = clog2_min1(NUM_CRAM);
  localparam int HI_W   = CRAM_DWIDTH - 32;
  localparam int LAT_W  = $clog2(RD_LAT + 1);

  state_t                 r_state;
  logic                   r_cmd_ready;
  logic                   r_rsp_valid;
  logic [31:0]            r_rsp_data;
  logic [LAT_W-1:0]       r_lat_cnt;
  logic [HI_W-1:0]        r_hi_latch;
  logic                   r_busy;
  logic                   r_done;
  logic                   r_exec_start;
  logic                   r_rf_wren;
  logic [RF_AWIDTH-1:0]   r_rf_addr;
  logic [RF_DWIDTH-1:0]   r_rf_data;

  logic [6:0]             w_f7;
  logic [2:0]             w_f3;
  logic                   w_accept;
  logic                   w_is_read;
  logic                   w_ptr_load;
  logic                   w_ptr_clear;
  logic                   w_capture;
  logic                   w_busy_eff;
  logic                   w_done_eff;
  logic                   w_start_ok;
  logic                   w_rf_write;
  logic [31:0]            w_rsp_imm;
  logic [31:0]            w_status;
  logic [CRAM_AWIDTH-1:0] w_ptr_addr;
  logic [BANK_W-1:0]      w_ptr_bank;
  logic                   w_ptr_wrap;
  logic [CRAM_DWIDTH-1:0] w_sel_word;
  logic [CRAM_DWIDTH-1:0] w_bank_word [NUM_CRAM];
  logic                   w_unused;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CRAM; gi++) begin : g_bank
      assign w_bank_word[gi] = cram_rd_data[gi*CRAM_DWIDTH +: CRAM_DWIDTH];
    end
  endgenerate

  assign w_sel_word = w_bank_word[w_ptr_bank];
  assign w_f7       = cmd_payload_function_id[9:3];
  assign w_f3       = cmd_payload_function_id[2:0];
  assign w_accept   = cmd_valid & r_cmd_ready;
  assign w_is_read  = (w_f3 == F3_READBACK) && (w_f7 == F7_RB_READ);
  assign w_ptr_load = w_accept && (w_f3 == F3_READBACK) && (w_f7 == F7_RB_CONFIG);
  assign w_ptr_clear = w_accept && (w_f3 == F3_SOFT_RST) && (w_f7 == F7_SOFT_RST);
  assign w_capture  = (r_state == ST_RD_WAIT) && (r_lat_cnt == '0);
  // exec_done is applied before a coincident START is judged
  assign w_busy_eff = r_busy & ~exec_done;
  assign w_done_eff = r_done | exec_done;
  assign w_unused   = ^{cmd_payload_inputs_0, cmd_payload_inputs_1};

  cram_rd_ptr #(
    .NUM_CRAM (NUM_CRAM),
    .AWIDTH   (CRAM_AWIDTH),
    .BANK_W   (BANK_W)
  ) u_ptr (
    .clk       (clk),
    .resetn    (resetn),
    .i_load    (w_ptr_load),
    .i_start   (cmd_payload_inputs_0[CRAM_AWIDTH-1:0]),
    .i_count   (cmd_payload_inputs_1),
    .i_clear   (w_ptr_clear),
    .i_advance (w_capture),
    .o_addr    (w_ptr_addr),
    .o_bank    (w_ptr_bank),
    .o_wrap    (w_ptr_wrap)
  );

  always_comb begin
    w_status             = '0;
    w_status[STAT_BUSY]  = w_busy_eff;
    w_status[STAT_DONE]  = w_done_eff;
    w_status[STAT_WRAP]  = w_ptr_wrap;
    w_rsp_imm            = RSP_UNSUPPORTED;
    w_start_ok           = 1'b0;
    w_rf_write           = 1'b0;
    case (w_f3)
      F3_SOFT_RST: w_rsp_imm = '0;
      F3_READBACK: begin
        case (w_f7)
          F7_RB_CONFIG: w_rsp_imm = '0;
          F7_RB_HI:     w_rsp_imm = 32'(r_hi_latch);
          default:      w_rsp_imm = RSP_UNSUPPORTED;
        endcase
      end
      F3_EXEC: begin
        case (w_f7)
          F7_EX_START: begin
            w_start_ok = w_accept & ~w_busy_eff;
            w_rsp_imm  = {31'b0, ~w_busy_eff};
          end
          F7_EX_STATUS: w_rsp_imm = w_status;
          F7_EX_RF_WRITE: begin
            w_rf_write = w_accept;
            w_rsp_imm  = 32'd1;
          end
          default: w_rsp_imm = RSP_UNSUPPORTED;
        endcase
      end
      default: w_rsp_imm = RSP_UNSUPPORTED;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state      <= ST_IDLE;
      r_cmd_ready  <= 1'b0;
      r_rsp_valid  <= 1'b0;
      r_rsp_data   <= '0;
      r_lat_cnt    <= '0;
      r_hi_latch   <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_exec_start <= 1'b0;
      r_rf_wren    <= 1'b0;
      r_rf_addr    <= '0;
      r_rf_data    <= '0;
    end else begin
      r_exec_start <= 1'b0;
      r_rf_wren    <= 1'b0;
      if (exec_done) begin
        r_busy <= 1'b0;
        r_done <= 1'b1;
      end
      case (r_state)
        ST_IDLE: begin
          r_cmd_ready <= 1'b1;
          if (w_accept) begin
            r_cmd_ready <= 1'b0;
            if (w_is_read) begin
              r_state   <= ST_RD_WAIT;
              r_lat_cnt <= LAT_W'(RD_LAT - 1);
            end else begin
              r_state     <= ST_RSP;
              r_rsp_valid <= 1'b1;
              r_rsp_data  <= w_rsp_imm;
            end
            if (w_ptr_clear) r_hi_latch <= '0;
            if (w_start_ok) begin
              r_exec_start <= 1'b1;
              r_busy       <= 1'b1;
              r_done       <= 1'b0;
            end
            if (w_rf_write) begin
              r_rf_wren <= 1'b1;
              r_rf_data <= cmd_payload_inputs_0[RF_DWIDTH-1:0];
              r_rf_addr <= cmd_payload_inputs_1[RF_AWIDTH-1:0];
            end
          end
        end
        ST_RD_WAIT: begin
          if (w_capture) begin
            r_rsp_data  <= w_sel_word[31:0];
            r_hi_latch  <= w_sel_word[CRAM_DWIDTH-1:32];
            r_rsp_valid <= 1'b1;
            r_state     <= ST_RSP;
          end else begin
            r_lat_cnt <= r_lat_cnt - 1'b1;
          end
        end
        ST_RSP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_cmd_ready <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign cmd_ready             = r_cmd_ready;
  assign rsp_valid             = r_rsp_valid;
  assign rsp_payload_outputs_0 = r_rsp_data;
  assign cram_rd_addr          = w_ptr_addr;
  assign exec_start            = r_exec_start;
  assign rf_wren               = r_rf_wren;
  assign rf_addr               = r_rf_addr;
  assign rf_data               = r_rf_data;
  assign busy                  = r_busy;

endmodule

// File: doc/cfu_cram_dispatch.md
# cfu_cram_dispatch

Parametrised CFU command front-end for a multi-bank CoMeFa compute-RAM array. Sits between the CPU CFU port and the CRAM banks, execution controller and register file. Generalises the fixed four-bank, single-cycle dispatcher in four ways:

- `NUM_CRAM` banks with configurable read latency;
- full `rsp_ready` back-pressure;
- an auto-incrementing readback pointer with bank wrap;
- a busy-guarded execute start.

## Interface

Parameters:

- `NUM_CRAM`, 4: number of CRAM banks (≥1).
- `CRAM_AWIDTH`, 9: CRAM address width.
- `CRAM_DWIDTH`, 40: CRAM word width (33..64).
- `RD_LAT`, 2: CRAM read latency in cycles, address to data (≥1).
- `RF_AWIDTH`, 2: register-file address width.
- `RF_DWIDTH`, 16: register-file data width.
- `BANK_W`, `$clog2(NUM_CRAM)` (minimum 1): derived, not overridable.

Ports:

- `clk`  in  1  single clock; all state on posedge.
- `resetn`  in  1  asynchronous, active-low reset.
- `cmd_valid`  in  1  command request.
- `cmd_ready`  out  1  command accept; reset 0.
- `cmd_payload_function_id`  in  10  [9:3] funct7, [2:0] funct3.
- `cmd_payload_inputs_0`  in  32  operand 0.
- `cmd_payload_inputs_1`  in  32  operand 1.
- `rsp_valid`  out  1  response valid; reset 0.
- `rsp_ready`  in  1  response accept.
- `rsp_payload_outputs_0`  out  32  response data; reset 0.
- `cram_rd_addr`  out  CRAM_AWIDTH  read address broadcast to all banks; reset 0.
- `cram_rd_data`  in  NUM_CRAM*CRAM_DWIDTH  flattened bank read data; bank b at [b*DW +: DW].
- `exec_start`  out  1  one-cycle pulse to the controller; reset 0.
- `exec_done`  in  1  one-cycle pulse from the controller.
- `rf_wren`  out  1  one-cycle register-file write; reset 0.
- `rf_addr`  out  RF_AWIDTH  register-file address; reset 0.
- `rf_data`  out  RF_DWIDTH  register-file data; reset 0.
- `busy`  out  1  execution in flight; reset 0.

## Operation

Commands are accepted on `cmd_valid & cmd_ready`. The function id and operands are registered at acceptance.

**funct3 = 0, SOFT_RST (funct7 = 1):**
- Clears the readback pointer: addr = start, bank = 0, elem = 0, wrap = 0.
- Clears `hi_latch`.
- Response 0.
- funct7 ≠ 1 returns 0 with no effect.

**funct3 = 6, READBACK:**
- funct7 = 0, CONFIG:
  - start = in0[CRAM_AWIDTH-1:0]; count = in1 (count 0 is treated as 1).
  - addr = start, bank = 0, elem = 0, wrap = 0.
  - Response 0.
- funct7 = 1, READ:
  - Drives `cram_rd_addr` = addr and waits RD_LAT cycles.
  - Selects bank `bank` from `cram_rd_data`.
  - Responds with word[31:0] and latches word[DW-1:32] into `hi_latch`.
  - Pointer advance: elem++ and addr++. When elem == count-1: elem = 0, addr = start, bank++. Bank wraps NUM_CRAM-1 → 0 and sets sticky `wrap`. Address arithmetic is modulo 2^CRAM_AWIDTH.
- funct7 = 2, HI: response = zero-extended `hi_latch`. No pointer change.

**funct3 = 7, EXEC:**
- funct7 = 0, START:
  - If !busy: pulse `exec_start`, set busy, clear sticky `done`, response 1.
  - If busy: response 0, no pulse.
- funct7 = 1, STATUS: response = {29'b0, wrap, done, busy}.
- funct7 = 2, RF_WRITE: `rf_wren` pulse with rf_data = in0[RF_DWIDTH-1:0] and rf_addr = in1[RF_AWIDTH-1:0]. Response 1.

**Other funct3 / funct7 values:** response 32'hFFFF_FFFF, no side effects.

**exec_done:** clears busy and sets `done`, in any state.
- Same-cycle START accept and exec_done: done is processed first, then the start is evaluated against the updated busy.

**FSM states:**
- IDLE (cmd_ready = 1): on accept, go to RD_WAIT if READ, else RSP.
- RD_WAIT: down-counter from RD_LAT; go to RSP when the data is captured.
- RSP (rsp_valid = 1): go to IDLE on rsp_ready.

## Timing

- `cmd_ready` rises 1 cycle after reset release. It is high only in IDLE.
- Non-READ latency: rsp_valid is asserted in the cycle after acceptance.
- READ latency: rsp_valid is asserted RD_LAT+1 cycles after acceptance.
- In RSP, `rsp_valid` and the payload hold stable until `rsp_ready`. The next command can be accepted the cycle after the handshake.
- Side-effect pulses (`exec_start`, `rf_wren`) occur in the cycle after acceptance, exactly once per command.
- The pointer advances at READ data capture. `cram_rd_addr` holds its value through RD_WAIT.
- Reset asserted mid-transaction clears everything asynchronously: the pending response is dropped, busy = 0, and `done`/`wrap` are cleared.

## Structure

- Package `cfu_cram_pkg`: funct3 opcodes (SOFT_RST, READBACK, EXEC), funct7 subcodes, the FSM state enum, the STATUS bit positions, and the unsupported-command code 32'hFFFF_FFFF.
- Sub-module `cram_rd_ptr`: start/count/addr/elem/bank/wrap counter, with load, advance and clear inputs.

## Test plan

- Reset release → cmd_ready = 1 after 1 cycle; all other outputs 0.
- CONFIG(start = 5, count = 2), then 8 READs with NUM_CRAM = 4 → addresses 5,6,5,6,…; banks 0,0,1,1,2,2,3,3. After the 8th READ, STATUS.wrap = 1.
- READ with bank data 40'hAB_1234_5678 and rsp_ready held low 5 cycles → rsp_valid stable with payload 32'h1234_5678 throughout. A following HI returns 32'h0000_00AB.
- START, then START again while busy → responses 1 then 0, exactly one exec_start pulse. After exec_done, STATUS = 3'b010.
- RF_WRITE(in0 = 16'h00FF, in1 = 2) → rf_wren pulse with rf_addr = 2 and rf_data = 16'h00FF; response 1.
- Assert resetn low during RD_WAIT → rsp_valid stays 0 and busy = 0. After release, a READ returns data from addr = start, bank 0.
